// File: rtl/mm_run_ctrl_pkg.sv
// Shared definitions for the matrix-multiply harness run controller.
// State encoding and default sizing constants.
package mm_defs;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RST_HOLD,
        ST_RUN,
        ST_DRAIN,
        ST_DONE,
        ST_TIMEOUT
    } run_state_e;

    localparam int MM_NUM_CH       = 4;
    localparam int MM_RST_HOLD     = 3;
    localparam int MM_DRAIN_CYCLES = 8;
    localparam int MM_CNT_W        = 16;
    localparam int MM_MAX_CYCLES   = 1000;
    localparam int MM_TMR_W        = 16;

endpackage

// File: rtl/mm_cycle_timer.sv
// Loadable down-counter; expired is high once the count has reached zero.
module mm_cycle_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expired
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expired = (cnt == '0);

endmodule

// File: rtl/mm_run_ctrl.sv
// Run sequencer: reset hold, gated run, drain, then DONE or TIMEOUT.
// Outputs are registered from the state held before each edge.
module mm_run_ctrl
    import mm_defs::*;
#(
    parameter int NUM_CH       = MM_NUM_CH,
    parameter int RST_HOLD     = MM_RST_HOLD,
    parameter int DRAIN_CYCLES = MM_DRAIN_CYCLES,
    parameter int CNT_W        = MM_CNT_W,
    parameter int MAX_CYCLES   = MM_MAX_CYCLES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [NUM_CH-1:0] ch_mask,
    input  logic [NUM_CH-1:0] ch_done,
    output logic              dut_rst_n,
    output logic [NUM_CH-1:0] clk_en,
    output logic              busy,
    output logic              done,
    output logic              timed_out,
    output logic [CNT_W-1:0]  cycle_count
);

    localparam int TW = MM_TMR_W;
    localparam logic [TW-1:0] HOLD_LD = TW'(RST_HOLD - 1);
    localparam logic [TW-1:0] DRAIN_LD = TW'(DRAIN_CYCLES - 1);
    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_CYCLES);

    run_state_e        state;
    logic [NUM_CH-1:0] mask_q;
    logic [NUM_CH-1:0] done_seen;
    logic              start_ok;
    logic              all_done;
    logic              at_limit;
    logic              tmr_load;
    logic              tmr_expired;
    logic [TW-1:0]     tmr_val;

    always_comb begin
        start_ok = start && (ch_mask != '0)
                && (state == ST_IDLE || state == ST_DONE
                    || state == ST_TIMEOUT);
        all_done = &(done_seen | ch_done | ~mask_q);
        at_limit = (MAX_CYCLES != 0)
                && ((cycle_count + CNT_W'(1)) == MAX_C);
        tmr_load = !abort
                && (start_ok || (state == ST_RUN && all_done));
        tmr_val  = (state == ST_RUN) ? DRAIN_LD : HOLD_LD;
    end

    // One timer covers both RST_HOLD and DRAIN; they never overlap.
    mm_cycle_timer #(
        .W(TW)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .load    (tmr_load),
        .load_val(tmr_val),
        .expired (tmr_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            mask_q      <= '0;
            done_seen   <= '0;
            cycle_count <= '0;
            dut_rst_n   <= 1'b0;
            clk_en      <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            timed_out   <= 1'b0;
        end else if (abort) begin
            state     <= ST_IDLE;
            dut_rst_n <= 1'b0;
            clk_en    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            timed_out <= 1'b0;
        end else begin
            dut_rst_n <= 1'b1;
            clk_en    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            timed_out <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    dut_rst_n <= 1'b0;
                end
                ST_RST_HOLD: begin
                    dut_rst_n <= 1'b0;
                    clk_en    <= mask_q;
                    busy      <= 1'b1;
                    if (tmr_expired) state <= ST_RUN;
                end
                ST_RUN: begin
                    clk_en    <= mask_q;
                    busy      <= 1'b1;
                    done_seen <= done_seen | (ch_done & mask_q);
                    if (cycle_count != '1)
                        cycle_count <= cycle_count + 1'b1;
                    if (all_done)
                        state <= ST_DRAIN;
                    else if (at_limit)
                        state <= ST_TIMEOUT;
                end
                ST_DRAIN: begin
                    clk_en <= mask_q;
                    busy   <= 1'b1;
                    if (tmr_expired) state <= ST_DONE;
                end
                ST_DONE: begin
                    done <= 1'b1;
                end
                ST_TIMEOUT: begin
                    timed_out <= 1'b1;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
            // Only legal in IDLE/DONE/TIMEOUT, so it cannot clash above.
            if (start_ok) begin
                mask_q      <= ch_mask;
                done_seen   <= '0;
                cycle_count <= '0;
                state       <= ST_RST_HOLD;
            end
        end
    end

endmodule
